arith_ctrl: RTL and testbench

ARITH_CTRL -- requirements
Module: ARITH_CTRL

---
 rtl/arith_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_arith_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_ctrl.sv
// Command sequencer for an external arithmetic unit. It issues one command at a time, holds the
// unit's result and queues results in a first-word-fall-through FIFO. Optional macro: ARITH_CTRL_TIMEOUT_EN.
module arith_ctrl #(
  parameter int A_width     = 16,
  parameter int B_width     = 16,
  parameter int OUT_width   = A_width + B_width,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                 CLK_CTRL,
  input  logic                 RST_CTRL,
  // command side
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [A_width-1:0]   CMD_A,
  input  logic [B_width-1:0]   CMD_B,
  input  logic [1:0]           CMD_FUN,
  // arithmetic-unit side
  output logic [A_width-1:0]   A_OUT,
  output logic [B_width-1:0]   B_OUT,
  output logic [1:0]           FUN_OUT,
  output logic                 EN_OUT,
  input  logic                 ARITH_FLAG_IN,
  input  logic                 CARRY_IN,
  input  logic [OUT_width-1:0] ARITH_RES_IN,
  // result side
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [OUT_width-1:0] RES_DATA,
  output logic                 RES_CARRY,
  output logic [1:0]           RES_FUN,
  output logic                 RES_ERR
);

  // FIFO_DEPTH must be a power of two and at least 2, so the pointers wrap on their own.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0] FUN_ADD = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OUT_width-1:0] data;
    logic                 carry;
    logic [1:0]           fun;
`ifdef ARITH_CTRL_TIMEOUT_EN
    logic                 err;
`endif
  } entry_t;

  state_t               state_q, state_d;
  logic                 first_wait_q;
  logic [OUT_width-1:0] hold_data_q;
  logic                 hold_carry_q;
  logic [OUT_width-1:0] wait_data;
  logic                 wait_carry;

  entry_t               mem [FIFO_DEPTH];
  entry_t               head;
  entry_t               push_entry;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 timeout;

  assign CMD_READY = (state_q == S_IDLE) && (count_q < DEPTH_C);
  assign accept    = CMD_VALID && CMD_READY;
  assign pop       = RES_VALID && RES_READY;

  // The unit's result is only valid in the first WAIT cycle, so an immediate flag bypasses the hold register.
  assign wait_data  = first_wait_q ? ARITH_RES_IN : hold_data_q;
  assign wait_carry = first_wait_q ? CARRY_IN     : hold_carry_q;

`ifdef ARITH_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q;

  assign timeout = (state_q == S_WAIT) && !ARITH_FLAG_IN && (to_cnt_q == TO_LAST);

  // The count equals the number of WAIT cycles already spent without a flag.
  always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
    if (!RST_CTRL) begin
      to_cnt_q <= '0;
    end else if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every output of an always_comb gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ARITH_FLAG_IN) begin
          push             = 1'b1;
          push_entry.data  = wait_data;
          push_entry.carry = (FUN_OUT == FUN_ADD) && wait_carry;
          push_entry.fun   = FUN_OUT;
          state_d          = S_IDLE;
        end else if (timeout) begin
          push           = 1'b1;
          push_entry.fun = FUN_OUT;
`ifdef ARITH_CTRL_TIMEOUT_EN
          push_entry.err = 1'b1;
`endif
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
    if (!RST_CTRL) begin
      state_q      <= S_IDLE;
      first_wait_q <= 1'b0;
      EN_OUT       <= 1'b0;
      A_OUT        <= '0;
      B_OUT        <= '0;
      FUN_OUT      <= '0;
      hold_data_q  <= '0;
      hold_carry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_wait_q <= (state_q == S_ISSUE);
      EN_OUT       <= accept;
      if (accept) begin
        A_OUT   <= CMD_A;
        B_OUT   <= CMD_B;
        FUN_OUT <= CMD_FUN;
      end
      if ((state_q == S_WAIT) && first_wait_q) begin
        hold_data_q  <= ARITH_RES_IN;
        hold_carry_q <= CARRY_IN;
      end
    end
  end

  // NOTE: the storage array has no reset; contents are ignored because occupancy clears on reset.
  always_ff @(posedge CLK_CTRL) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
    if (!RST_CTRL) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head outputs read zero while the FIFO is empty, which also gives the reset values.
  assign head      = mem[rd_ptr_q];
  assign RES_VALID = (count_q != '0);
  assign RES_DATA  = RES_VALID ? head.data : '0;
  assign RES_CARRY = RES_VALID && head.carry;
  assign RES_FUN   = RES_VALID ? head.fun : 2'b00;
`ifdef ARITH_CTRL_TIMEOUT_EN
  assign RES_ERR   = RES_VALID && head.err;
`else
  assign RES_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_arith_ctrl.sv
// Directed bench for arith_ctrl, with a one-cycle-latency arithmetic unit model.
// The model returns garbage after the valid cycle, so results taken after the first WAIT cycle must come from the hold register.
module tb_arith_ctrl;

  logic        CLK_CTRL = 1'b0;
  logic        RST_CTRL = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [15:0] CMD_A = '0;
  logic [15:0] CMD_B = '0;
  logic [1:0]  CMD_FUN = '0;
  logic [15:0] A_OUT;
  logic [15:0] B_OUT;
  logic [1:0]  FUN_OUT;
  logic        EN_OUT;
  logic        ARITH_FLAG_IN;
  logic        CARRY_IN;
  logic [31:0] ARITH_RES_IN;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [31:0] RES_DATA;
  logic        RES_CARRY;
  logic [1:0]  RES_FUN;
  logic        RES_ERR;

  arith_ctrl dut (
    .CLK_CTRL(CLK_CTRL), .RST_CTRL(RST_CTRL),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
    .A_OUT(A_OUT), .B_OUT(B_OUT), .FUN_OUT(FUN_OUT), .EN_OUT(EN_OUT),
    .ARITH_FLAG_IN(ARITH_FLAG_IN), .CARRY_IN(CARRY_IN), .ARITH_RES_IN(ARITH_RES_IN),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_CARRY(RES_CARRY), .RES_FUN(RES_FUN), .RES_ERR(RES_ERR)
  );

  always #5 CLK_CTRL = ~CLK_CTRL;

  // ---- arithmetic unit model -------------------------------------------
  int          flag_delay  = 0;
  bit          flag_enable = 1'b1;
  logic        unit_busy;
  int          unit_cnt;
  logic [31:0] unit_res;
  logic        unit_carry;

  always @(posedge CLK_CTRL or negedge RST_CTRL) begin
    if (!RST_CTRL) begin
      unit_busy  <= 1'b0;
      unit_cnt   <= 0;
      unit_res   <= '0;
      unit_carry <= 1'b0;
    end else if (EN_OUT) begin
      unit_busy <= 1'b1;
      unit_cnt  <= flag_delay;
      case (FUN_OUT)
        2'b00: begin
          unit_res   <= 32'(A_OUT) + 32'(B_OUT);
          unit_carry <= (17'(A_OUT) + 17'(B_OUT)) >> 16 != 17'd0;
        end
        2'b01: begin
          unit_res   <= 32'(A_OUT) - 32'(B_OUT);
          unit_carry <= 1'b1;
        end
        2'b10: begin
          unit_res   <= 32'(A_OUT) * 32'(B_OUT);
          unit_carry <= 1'b1;
        end
        default: begin
          unit_res   <= (B_OUT == 16'd0) ? 32'hFFFF_FFFF : {A_OUT % B_OUT, A_OUT / B_OUT};
          unit_carry <= 1'b1;
        end
      endcase
    end else if (unit_busy) begin
      unit_res   <= 32'hDEAD_BEEF;
      unit_carry <= ~unit_carry;
      if (unit_cnt == 0) begin
        if (flag_enable) unit_busy <= 1'b0;
      end else begin
        unit_cnt <= unit_cnt - 1;
      end
    end
  end

  assign ARITH_RES_IN  = unit_res;
  assign CARRY_IN      = unit_carry;
  assign ARITH_FLAG_IN = unit_busy && (unit_cnt == 0) && flag_enable;

  int en_cycles = 0;
  always @(negedge CLK_CTRL) if (EN_OUT) en_cycles = en_cycles + 1;

  // ---- helpers ---------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_CTRL);
      #1;
    end
  endtask

  // Returns one cycle after the accepting edge (DUT is then in ISSUE).
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
    bit ok;
    ok        = 1'b0;
    CMD_A     = a;
    CMD_B     = b;
    CMD_FUN   = f;
    CMD_VALID = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (CMD_READY) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    CMD_VALID = 1'b0;
    check("cmd_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (RES_VALID) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("res_valid_within_budget", 64'(ok), 64'd1);
  endtask

  task automatic pop();
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
  endtask

  task automatic do_reset();
    #2 RST_CTRL = 1'b0;
    tick(2);
    @(negedge CLK_CTRL);
    RST_CTRL = 1'b1;
    #1;
  endtask

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  fun;
    int          dly;
    logic [31:0] exp_data;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"add_carry",  16'hFFFF, 16'h0001, 2'b00, 0, 32'h0001_0000, 1'b1};
    vecs[1] = '{"mul",        16'h00FF, 16'h0100, 2'b10, 0, 32'h0000_FF00, 1'b0};
    vecs[2] = '{"sub_held",   16'h0005, 16'h0007, 2'b01, 2, 32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{"div_held",   16'h0064, 16'h0007, 2'b11, 1, 32'h0002_000E, 1'b0};
    vecs[4] = '{"add_nocar",  16'h1234, 16'h4321, 2'b00, 3, 32'h0000_5555, 1'b0};
    vecs[5] = '{"add_held_c", 16'h8000, 16'h8000, 2'b00, 1, 32'h0001_0000, 1'b1};

    // ---- reset state ----
    #12;
    check("rst_en_out",    64'(EN_OUT),    64'd0);
    check("rst_a_out",     64'(A_OUT),     64'd0);
    check("rst_b_out",     64'(B_OUT),     64'd0);
    check("rst_fun_out",   64'(FUN_OUT),   64'd0);
    check("rst_res_valid", 64'(RES_VALID), 64'd0);
    check("rst_res_data",  64'(RES_DATA),  64'd0);
    check("rst_res_carry", 64'(RES_CARRY), 64'd0);
    check("rst_res_fun",   64'(RES_FUN),   64'd0);
    check("rst_res_err",   64'(RES_ERR),   64'd0);
    @(negedge CLK_CTRL);
    RST_CTRL = 1'b1;
    #1;
    check("rst_cmd_ready_first", 64'(CMD_READY), 64'd1);

    // ---- table-driven single commands ----
    foreach (vecs[i]) begin
      int en0;
      flag_delay = vecs[i].dly;
      en0 = en_cycles;
      issue(vecs[i].a, vecs[i].b, vecs[i].fun);
      wait_valid(20);
      check({vecs[i].name, "_data"},  64'(RES_DATA),  64'(vecs[i].exp_data));
      check({vecs[i].name, "_carry"}, 64'(RES_CARRY), 64'(vecs[i].exp_carry));
      check({vecs[i].name, "_fun"},   64'(RES_FUN),   64'(vecs[i].fun));
      check({vecs[i].name, "_err"},   64'(RES_ERR),   64'd0);
      check({vecs[i].name, "_en_1cyc"}, 64'(en_cycles - en0), 64'd1);
      check({vecs[i].name, "_a_held"}, 64'({A_OUT, B_OUT, FUN_OUT}),
            64'({vecs[i].a, vecs[i].b, vecs[i].fun}));
      pop();
      check({vecs[i].name, "_popped"}, 64'(RES_VALID), 64'd0);
    end

    // ---- backpressure: 4 stored, 5th waits for a pop ----
    flag_delay = 0;
    for (int k = 1; k <= 4; k++) issue(16'(k * 16'h1000), 16'(k), 2'b00);
    tick(2);
    check("bp_ready_low_full", 64'(CMD_READY), 64'd0);
    check("bp_head_first",     64'(RES_DATA),  64'h1001);
    CMD_A = 16'h5000; CMD_B = 16'h0005; CMD_FUN = 2'b00; CMD_VALID = 1'b1;
    tick(3);
    check("bp_still_blocked", 64'(CMD_READY), 64'd0);
    check("bp_a_out_held",    64'(A_OUT),     64'h4000);
    pop();
    check("bp_ready_after_pop", 64'(CMD_READY), 64'd1);
    check("bp_head_second",     64'(RES_DATA),  64'h2002);
    tick();
    CMD_VALID = 1'b0;
    check("bp_fifth_issued", 64'({EN_OUT, A_OUT}), 64'({1'b1, 16'h5000}));
    tick(2);
    for (int k = 2; k <= 5; k++) begin
      check("bp_drain_valid", 64'(RES_VALID), 64'd1);
      check("bp_drain_order", 64'(RES_DATA),  64'(k * 32'h1001));
      pop();
    end
    check("bp_drained_empty", 64'(RES_VALID), 64'd0);

    // ---- simultaneous push and pop with 3 queued ----
    for (int k = 1; k <= 3; k++) issue(16'(k * 16'h0100), 16'(k), 2'b00);
    tick(2);
    issue(16'h0400, 16'h0004, 2'b00);
    tick();
    check("pp_head_before", 64'(RES_DATA), 64'h0101);
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    check("pp_head_advanced", 64'(RES_DATA), 64'h0202);
    for (int k = 2; k <= 4; k++) begin
      check("pp_drain_valid", 64'(RES_VALID), 64'd1);
      check("pp_drain_order", 64'(RES_DATA),  64'(k * 32'h0101));
      pop();
    end
    check("pp_occupancy_was_3", 64'(RES_VALID), 64'd0);

    // ---- WAIT without flag ----
    flag_enable = 1'b0;
    issue(16'h0003, 16'h0001, 2'b01);
`ifdef ARITH_CTRL_TIMEOUT_EN
    tick(15);
    check("to_not_before_15", 64'(RES_VALID), 64'd0);
    tick();
    check("to_entry_valid", 64'(RES_VALID), 64'd1);
    check("to_entry_data",  64'(RES_DATA),  64'd0);
    check("to_entry_err",   64'(RES_ERR),   64'd1);
    check("to_entry_carry", 64'(RES_CARRY), 64'd0);
    check("to_entry_fun",   64'(RES_FUN),   64'd1);
    check("to_back_idle",   64'(CMD_READY), 64'd1);
    pop();
`else
    tick(40);
    check("noto_no_entry",  64'(RES_VALID), 64'd0);
    check("noto_stay_wait", 64'(CMD_READY), 64'd0);
    check("noto_err_tied",  64'(RES_ERR),   64'd0);
`endif
    flag_enable = 1'b1;
    do_reset();

    // ---- reset during WAIT with 2 queued ----
    for (int k = 1; k <= 2; k++) issue(16'(k), 16'h0010, 2'b00);
    tick(2);
    flag_enable = 1'b0;
    issue(16'h0777, 16'h0001, 2'b00);
    tick(3);
    check("rw_queued_before", 64'({RES_VALID, RES_DATA}), 64'({1'b1, 32'h0011}));
    #2 RST_CTRL = 1'b0;
    #1;
    check("rw_valid_dropped", 64'(RES_VALID), 64'd0);
    check("rw_data_zero",     64'(RES_DATA),  64'd0);
    check("rw_a_out_zero",    64'(A_OUT),     64'd0);
    flag_enable = 1'b1;
    tick();
    @(negedge CLK_CTRL);
    RST_CTRL = 1'b1;
    #1;
    check("rw_ready_first", 64'(CMD_READY), 64'd1);
    tick();
    check("rw_ready_cycle1", 64'(CMD_READY), 64'd1);
    tick(5);
    check("rw_no_push", 64'(RES_VALID), 64'd0);
    check("rw_en_low",  64'(EN_OUT),    64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
